q_fwd_landing: RTL and testbench
================================

// Module: q_fwd_landing
// PURPOSE
//  - Landing queue at the downstream end of a forward-pipelined interconnect (1..256 stages).
//  - Absorbs every item already in flight in the pipe when back-pressure rises, so none is lost.
//  - Raises back-pressure early, by a margin equal to the pipe latency (SLACK).
//  - Presents a first-word-fall-through stream to the consuming operator.
// PARAMETERS
//  depth      16   queue capacity in items; require depth >= slack+2, depth <= 256
//  width      16   data width incl. concatenated EOS bit (i_d, o_d)
//  slack       1   forward stages between producer and this block (= upstream pipe depth)
//  addrwidth   8   pointer width; must satisfy 2**addrwidth >= depth
// PORTS
//  clock     in   1          single clock, all state on posedge
//  reset     in   1          synchronous, active-high
//  i_d       in   width      input stream data (data+eos), from last pipe stage
//  i_v       in   1          input stream valid
//  i_b       out  1          input back-pressure toward producer (passes through pipe), registered
//  o_d       out  width      output stream data, head of queue
//  o_v       out  1          output valid: queue non-empty
//  o_b       in   1          output back-pressure from consumer (1 = do not send)
//  overflow  out  1          sticky error: an arriving item was dropped
// BEHAVIOUR
//  - Reset (sync, high): count=0, rd/wr ptr=0, o_v=0, i_b=1, overflow=0.
//    i_v during reset is ignored. Memory is not cleared; o_d is undefined while o_v=0.
//    Reset mid-operation discards all contents the same way.
//  - pop  = o_v & !o_b.
//  - push = i_v & (count<depth | pop).
//    i_v is NOT qualified by i_b: in-flight items arrive regardless.
//  - count_next = count + push - pop. Width is addrwidth+1 bits. Pointers wrap at depth-1 -> 0,
//    not at 2**addrwidth.
//  - Push writes mem[wr_ptr] on the clock edge; pop advances rd_ptr.
//    Simultaneous push+pop when full or empty is legal.
//  - When empty, a push makes o_v=1 on the next cycle. No same-cycle bypass.
//  - o_d = mem[rd_ptr] (combinational read of the registered array). Latency in->out = 1 cycle.
//  - i_b <= (count_next >= depth-slack); forced to 1 in reset.
//    Guarantee: if i_b=0 in cycle t, then count(t)+slack+1 <= depth, so all in-flight items fit.
//  - overflow <= overflow | (i_v & count==depth & !pop). The dropped item leaves state unchanged.
//  - EOS is ordinary data here; no special handling.
//  - No combinational path from o_b to i_b, or from i_v to o_v.
// STRUCTURE
//  - Shared include q_common.vh:
//    - LOG2 constant-function macro (the depth->addrwidth ternary chain);
//    - `define Q_BP_INIT 1'b1 for the back-pressure reset value.
//  - One sub-module q_landing_mem: depth x width register file, one write port, one async
//    read port, no reset.
//  - Top holds pointers, count, i_b / overflow registers (~150-250 lines total).
// TESTING
//  1. Reset held 3 cycles with i_v=1 -> i_b=1, o_v=0, count 0.
//     Release: i_b=0 next cycle, nothing enqueued.
//  2. depth=16, slack=1, o_b=1, stream i_v=1 with i_d=0..N:
//     - i_b rises after count reaches 15;
//     - upstream obeys i_b through a 1-stage pipe;
//     - 16 items stored, overflow stays 0.
//  3. Full queue, force i_v=1 ignoring i_b, o_b=1 -> item dropped, overflow=1 and stays 1
//     until reset; contents intact.
//  4. Full queue, i_v=1 and o_b=0 same cycle -> push and pop both happen, count stays 16,
//     o_d order preserved 0,1,2...
//  5. Continuous i_v=1, o_b=0 -> one item out per cycle after 1-cycle latency;
//     pointers wrap past 15 with correct order; i_b stays 0.
//  6. Reset asserted mid-stream with count=9 -> next cycle o_v=0, i_b=1, count=0;
//     first item after release emerges first.

Source files
------------

// File: rtl/q_fwd_landing_pkg.sv
// Shared constants and helpers for the forward-pipeline landing queue.
package q_fwd_landing_pkg;

    // Back-pressure asserted while in reset so nothing is launched into the pipe.
    localparam logic BP_INIT = 1'b1;

    function automatic int q_log2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction

endpackage

// File: rtl/q_fwd_landing_if.sv
// Valid/back-pressure stream: master drives data+valid, slave drives back-pressure.
interface q_fwd_landing_if #(
    parameter int width = 16
) ();
    logic [width-1:0] d;
    logic             v;
    logic             b;

    modport master (output d, output v, input b);
    modport slave  (input d, input v, output b);
endinterface

// File: rtl/q_landing_mem.sv
// Register file for the landing queue: one write port, one async read port, no reset.
module q_landing_mem #(
    parameter int depth = 16,
    parameter int width = 16,
    parameter int iw    = 4
) (
    input  logic             clock,
    input  logic             we,
    input  logic [iw-1:0]    waddr,
    input  logic [iw-1:0]    raddr,
    input  logic [width-1:0] wdata,
    output logic [width-1:0] rdata
);
    logic [width-1:0] mem [depth];

    always_ff @(posedge clock) begin
        if (we) mem[waddr] <= wdata;
    end

    assign rdata = mem[raddr];
endmodule

// File: rtl/q_fwd_landing.sv
// Landing queue at the end of a forward pipe: absorbs in-flight items, raises
// back-pressure slack entries early, and presents a first-word-fall-through output.
module q_fwd_landing
    import q_fwd_landing_pkg::*;
#(
    parameter int depth     = 16,
    parameter int width     = 16,
    parameter int slack     = 1,
    parameter int addrwidth = 8
) (
    input  logic                clock,
    input  logic                reset,
    q_fwd_landing_if.slave      in_s,
    q_fwd_landing_if.master     out_s,
    output logic                overflow
);
    localparam int                 IW       = q_log2(depth);
    localparam logic [addrwidth:0] DEPTH_C  = (addrwidth+1)'(depth);
    localparam logic [addrwidth:0] BP_TH    = (addrwidth+1)'(depth - slack);
    localparam logic [addrwidth-1:0] PTR_LAST = addrwidth'(depth - 1);

    logic [addrwidth:0]   count, count_next;
    logic [addrwidth-1:0] rd_ptr, wr_ptr;
    logic                 push, pop, full, bp;

    // Pointers wrap at depth-1, which need not be a power of two.
    function automatic logic [addrwidth-1:0] ptr_inc(input logic [addrwidth-1:0] p);
        return (p == PTR_LAST) ? '0 : p + 1'b1;
    endfunction

    assign out_s.v    = (count != '0);
    assign pop        = out_s.v & ~out_s.b;
    assign full       = (count == DEPTH_C);
    // Arrivals are not gated by our own back-pressure: they were already in flight.
    assign push       = in_s.v & (~full | pop);
    assign count_next = count + (addrwidth+1)'(push) - (addrwidth+1)'(pop);
    assign in_s.b     = bp;

    always_ff @(posedge clock) begin
        if (reset) begin
            count    <= '0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            bp       <= BP_INIT;
            overflow <= 1'b0;
        end else begin
            count    <= count_next;
            if (push) wr_ptr <= ptr_inc(wr_ptr);
            if (pop)  rd_ptr <= ptr_inc(rd_ptr);
            bp       <= (count_next >= BP_TH);
            overflow <= overflow | (in_s.v & full & ~pop);
        end
    end

    q_landing_mem #(
        .depth (depth),
        .width (width),
        .iw    (IW)
    ) u_mem (
        .clock (clock),
        .we    (push),
        .waddr (wr_ptr[IW-1:0]),
        .raddr (rd_ptr[IW-1:0]),
        .wdata (in_s.d),
        .rdata (out_s.d)
    );
endmodule

// File: tb/tb_q_fwd_landing.sv
// Bench for q_fwd_landing: randomized stimulus against a queue-level reference model.
module tb_q_fwd_landing;
    localparam int DEPTH = 16;
    localparam int WIDTH = 16;
    localparam int SLACK = 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic overflow;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    q_fwd_landing_if #(.width(WIDTH)) in_s ();
    q_fwd_landing_if #(.width(WIDTH)) out_s ();

    q_fwd_landing #(
        .depth(DEPTH), .width(WIDTH), .slack(SLACK), .addrwidth(8)
    ) dut (
        .clock(clk), .reset(rst), .in_s(in_s), .out_s(out_s), .overflow(overflow)
    );

    // Reference model: contents as a FIFO queue plus the two flags.
    logic [WIDTH-1:0] q[$];
    bit m_ovf = 1'b0;
    bit m_ib  = 1'b1;

    task automatic tick();
        bit pop;
        if (rst) begin
            q.delete();
            m_ib  = 1'b1;
            m_ovf = 1'b0;
        end else begin
            pop = (q.size() != 0) && !out_s.b;
            if (in_s.v && q.size() == DEPTH && !pop) m_ovf = 1'b1;
            if (pop) void'(q.pop_front());
            if (in_s.v && q.size() < DEPTH) q.push_back(in_s.d);
            m_ib = (q.size() >= DEPTH - SLACK);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_s.v = 1'b1; out_s.b = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_s.d = WIDTH'($urandom);
            tick();
            checks++;
            if (in_s.b !== 1'b1) begin errors++; $display("FAIL reset_ib cyc %0d got %b exp 1", i, in_s.b); end
            checks++;
            if (out_s.v !== 1'b0) begin errors++; $display("FAIL reset_ov cyc %0d got %b exp 0", i, out_s.v); end
            checks++;
            if (overflow !== 1'b0) begin errors++; $display("FAIL reset_ovf got %b exp 0", overflow); end
        end
        rst = 1'b0; in_s.v = 1'b0;
        tick();
        checks++;
        if (in_s.b !== 1'b0) begin errors++; $display("FAIL release_ib got %b exp 0", in_s.b); end
        checks++;
        if (out_s.v !== 1'b0) begin errors++; $display("FAIL release_ov got %b exp 0", out_s.v); end
    endtask

    // Producer obeys i_b through a one-stage forward pipe; consumer stalled.
    task automatic test_fill();
        logic             pv = 1'b0, nv;
        logic [WIDTH-1:0] pd = '0, nd;
        int               next = 0;
        out_s.b = 1'b1;
        for (int i = 0; i < 24; i++) begin
            in_s.v = pv; in_s.d = pd;
            checks++;
            if (in_s.b !== m_ib) begin errors++; $display("FAIL fill_ib cyc %0d got %b exp %b", i, in_s.b, m_ib); end
            checks++;
            if (overflow !== 1'b0) begin errors++; $display("FAIL fill_ovf cyc %0d got %b exp 0", i, overflow); end
            nv = !in_s.b;
            nd = pd;
            if (nv) begin nd = WIDTH'(next); next++; end
            tick();
            pv = nv; pd = nd;
        end
        in_s.v = 1'b0;
        checks++;
        if (next !== DEPTH) begin errors++; $display("FAIL fill_issued got %0d exp %0d", next, DEPTH); end
        checks++;
        if (out_s.v !== 1'b1 || out_s.d !== q[0]) begin
            errors++; $display("FAIL fill_head got v=%b d=%h exp v=1 d=%h", out_s.v, out_s.d, q[0]);
        end
    endtask

    task automatic test_overflow();
        in_s.v = 1'b1; in_s.d = WIDTH'($urandom); out_s.b = 1'b1;
        tick();
        in_s.v = 1'b0;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (overflow !== m_ovf || !m_ovf) begin errors++; $display("FAIL ovf_sticky cyc %0d got %b exp 1", i, overflow); end
            checks++;
            if (out_s.d !== q[0]) begin errors++; $display("FAIL ovf_head got %h exp %h", out_s.d, q[0]); end
            tick();
        end
    endtask

    // Full queue with simultaneous push and pop, then drain and check order.
    task automatic test_full_push_pop();
        for (int k = 0; k < 5; k++) begin
            in_s.v = 1'b1; in_s.d = WIDTH'(16'h100 + k); out_s.b = 1'b0;
            checks++;
            if (out_s.v !== 1'b1 || out_s.d !== q[0]) begin
                errors++; $display("FAIL fpp_head k=%0d got v=%b d=%h exp d=%h", k, out_s.v, out_s.d, q[0]);
            end
            tick();
            checks++;
            if (in_s.b !== m_ib) begin errors++; $display("FAIL fpp_ib k=%0d got %b exp %b", k, in_s.b, m_ib); end
        end
        in_s.v = 1'b0;
        for (int i = 0; i < 2 * DEPTH && q.size() != 0; i++) begin
            checks++;
            if (out_s.v !== 1'b1 || out_s.d !== q[0]) begin
                errors++; $display("FAIL drain_order i=%0d got v=%b d=%h exp d=%h", i, out_s.v, out_s.d, q[0]);
            end
            tick();
        end
        checks++;
        if (out_s.v !== 1'b0) begin errors++; $display("FAIL drain_empty got %b exp 0", out_s.v); end
        checks++;
        if (overflow !== m_ovf) begin errors++; $display("FAIL drain_ovf got %b exp %b", overflow, m_ovf); end
    endtask

    task automatic test_stream();
        rst = 1'b1; tick(); rst = 1'b0; tick();
        for (int i = 0; i < 40; i++) begin
            in_s.v = 1'b1; in_s.d = WIDTH'($urandom); out_s.b = 1'b0;
            checks++;
            if (out_s.v !== (q.size() != 0)) begin errors++; $display("FAIL stream_ov i=%0d got %b exp %b", i, out_s.v, q.size() != 0); end
            if (q.size() != 0) begin
                checks++;
                if (out_s.d !== q[0]) begin errors++; $display("FAIL stream_d i=%0d got %h exp %h", i, out_s.d, q[0]); end
            end
            checks++;
            if (in_s.b !== 1'b0 || m_ib) begin errors++; $display("FAIL stream_ib i=%0d got %b exp 0", i, in_s.b); end
            tick();
        end
        in_s.v = 1'b0;
    endtask

    task automatic test_random();
        rst = 1'b1; tick(); rst = 1'b0;
        for (int i = 0; i < 400; i++) begin
            in_s.v  = ($urandom % 4) != 0;
            in_s.d  = WIDTH'($urandom);
            out_s.b = ((i / 50) % 2 == 0) ? (($urandom % 4) != 0) : (($urandom % 4) == 0);
            checks++;
            if (out_s.v !== (q.size() != 0)) begin errors++; $display("FAIL rand_ov i=%0d got %b exp %b", i, out_s.v, q.size() != 0); end
            if (q.size() != 0) begin
                checks++;
                if (out_s.d !== q[0]) begin errors++; $display("FAIL rand_d i=%0d got %h exp %h", i, out_s.d, q[0]); end
            end
            checks++;
            if (in_s.b !== m_ib) begin errors++; $display("FAIL rand_ib i=%0d got %b exp %b", i, in_s.b, m_ib); end
            checks++;
            if (overflow !== m_ovf) begin errors++; $display("FAIL rand_ovf i=%0d got %b exp %b", i, overflow, m_ovf); end
            tick();
        end
        in_s.v = 1'b0;
    endtask

    task automatic test_mid_reset();
        rst = 1'b1; tick(); rst = 1'b0;
        out_s.b = 1'b1;
        for (int k = 0; k < 9; k++) begin
            in_s.v = 1'b1; in_s.d = WIDTH'(k);
            tick();
        end
        checks++;
        if (out_s.v !== 1'b1 || out_s.d !== q[0]) begin errors++; $display("FAIL mid_pre got v=%b d=%h exp d=%h", out_s.v, out_s.d, q[0]); end
        rst = 1'b1; in_s.d = 16'h5555;
        tick();
        checks++;
        if (out_s.v !== 1'b0) begin errors++; $display("FAIL mid_ov got %b exp 0", out_s.v); end
        checks++;
        if (in_s.b !== 1'b1) begin errors++; $display("FAIL mid_ib got %b exp 1", in_s.b); end
        rst = 1'b0; in_s.v = 1'b1; in_s.d = 16'hABCD;
        tick();
        in_s.v = 1'b0;
        checks++;
        if (out_s.v !== 1'b1 || out_s.d !== 16'hABCD) begin errors++; $display("FAIL mid_first got v=%b d=%h exp v=1 d=abcd", out_s.v, out_s.d); end
        checks++;
        if (in_s.b !== m_ib || overflow !== 1'b0) begin errors++; $display("FAIL mid_flags got ib=%b ovf=%b exp ib=%b ovf=0", in_s.b, overflow, m_ib); end
    endtask

    initial begin
        in_s.v = 1'b1; in_s.d = '0; out_s.b = 1'b1;
        test_reset();
        test_fill();
        test_overflow();
        test_full_push_pop();
        test_stream();
        test_random();
        test_mid_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
